// File: rtl/robot_position_tracker.sv
// Robot position tracker: world-side responder to the robot controller.
// Holds the robot pose, executes move commands and re-senses the head and
// left walls from the map ROM after every command.
module robot_position_tracker #(
  parameter int         ROWS         = 10,
  parameter int         COLS         = 20,
  parameter int         START_ROW    = 1,
  parameter int         START_COL    = 1,
  parameter logic [1:0] START_ORIENT = 2'b00
) (
  input  logic        clock_50,
  input  logic        reset_key,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_code,
  output logic        cmd_ready,
  output logic        cmd_done,
  output logic        collision,
  output logic        map_rd_en,
  output logic [5:0]  map_rd_row,
  output logic [5:0]  map_rd_col,
  input  logic        map_wall,
  output logic [5:0]  robot_row,
  output logic [5:0]  robot_column,
  output logic [1:0]  robot_orientation,
  output logic        head_blocked,
  output logic        left_blocked,
  output logic        sensors_valid,
  output logic [15:0] move_count
);

  localparam logic [5:0] ROW_MAX = 6'(ROWS);
  localparam logic [5:0] COL_MAX = 6'(COLS);

  localparam logic [1:0] OR_N = 2'b00;
  localparam logic [1:0] OR_S = 2'b01;
  localparam logic [1:0] OR_E = 2'b10;
  localparam logic [1:0] OR_W = 2'b11;

  localparam logic [1:0] CMD_FWD   = 2'b00;
  localparam logic [1:0] CMD_LEFT  = 2'b01;
  localparam logic [1:0] CMD_RIGHT = 2'b10;

  typedef enum logic [2:0] {
    Q_HEAD = 3'd0,
    W_HEAD = 3'd1,
    Q_LEFT = 3'd2,
    W_LEFT = 3'd3,
    READY  = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] look_dir;
  logic [5:0] nb_row, nb_col;
  logic       nb_oob;
  logic       accept;

  function automatic logic [1:0] left_of(input logic [1:0] o);
    case (o)
      OR_N:    return OR_W;
      OR_W:    return OR_S;
      OR_S:    return OR_E;
      default: return OR_N;
    endcase
  endfunction

  function automatic logic [1:0] right_of(input logic [1:0] o);
    case (o)
      OR_N:    return OR_E;
      OR_E:    return OR_S;
      OR_S:    return OR_W;
      default: return OR_N;
    endcase
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign accept = cmd_ready & cmd_valid;

  // Neighbour cell: left-hand cell while sensing the left wall, otherwise the cell ahead
  always_comb begin
    look_dir = robot_orientation;
    if (state == Q_LEFT || state == W_LEFT)
      look_dir = left_of(robot_orientation);
    nb_row = robot_row;
    nb_col = robot_column;
    case (look_dir)
      OR_N:    nb_row = robot_row - 6'd1;
      OR_S:    nb_row = robot_row + 6'd1;
      OR_E:    nb_col = robot_column + 6'd1;
      default: nb_col = robot_column - 6'd1;
    endcase
    nb_oob = (nb_row == 6'd0) || (nb_row > ROW_MAX) ||
             (nb_col == 6'd0) || (nb_col > COL_MAX);
  end

  // State register
  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) state <= Q_HEAD;
    else            state <= state_nxt;
  end

  // Next-state: fixed four-cycle sense sequence, then wait for a command
  always_comb begin
    state_nxt = state;
    case (state)
      Q_HEAD:  state_nxt = W_HEAD;
      W_HEAD:  state_nxt = Q_LEFT;
      Q_LEFT:  state_nxt = W_LEFT;
      W_LEFT:  state_nxt = READY;
      READY:   state_nxt = accept ? Q_HEAD : READY;
      default: state_nxt = Q_HEAD;
    endcase
  end

  // Outputs: map reads only for in-map neighbours; suppressed while reset is held
  always_comb begin
    cmd_ready     = (state == READY);
    sensors_valid = (state == READY);
    map_rd_en     = 1'b0;
    map_rd_row    = 6'd0;
    map_rd_col    = 6'd0;
    if (reset_key && (state == Q_HEAD || state == Q_LEFT) && !nb_oob) begin
      map_rd_en  = 1'b1;
      map_rd_row = nb_row;
      map_rd_col = nb_col;
    end
  end

  // Sensor registers: forced blocked off-map, otherwise loaded from the map data
  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      head_blocked <= 1'b1;
      left_blocked <= 1'b1;
    end else begin
      case (state)
        Q_HEAD:  if (nb_oob)  head_blocked <= 1'b1;
        W_HEAD:  if (!nb_oob) head_blocked <= map_wall;
        Q_LEFT:  if (nb_oob)  left_blocked <= 1'b1;
        W_LEFT:  if (!nb_oob) left_blocked <= map_wall;
        default: ;
      endcase
    end
  end

  // Pose update and completion pulses on command acceptance
  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      robot_row         <= 6'(START_ROW);
      robot_column      <= 6'(START_COL);
      robot_orientation <= START_ORIENT;
      move_count        <= 16'd0;
      cmd_done          <= 1'b0;
      collision         <= 1'b0;
    end else begin
      cmd_done  <= accept;
      collision <= 1'b0;
      if (accept) begin
        case (cmd_code)
          CMD_FWD: begin
            if (head_blocked) begin
              collision <= 1'b1;
            end else begin
              robot_row    <= nb_row;
              robot_column <= nb_col;
              move_count   <= sat_inc(move_count);
            end
          end
          CMD_LEFT:  robot_orientation <= left_of(robot_orientation);
          CMD_RIGHT: robot_orientation <= right_of(robot_orientation);
          default:   ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_robot_position_tracker.sv
// Directed bench for robot_position_tracker: table of commands with expected
// pose/sensors, plus hand sequences for walking, reset abort and held valid.
module tb_robot_position_tracker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic [1:0]  cmd_code;
  logic        cmd_ready, cmd_done, collision, map_rd_en;
  logic [5:0]  map_rd_row, map_rd_col;
  logic        map_wall = 1'b0;
  logic [5:0]  robot_row, robot_column;
  logic [1:0]  robot_orientation;
  logic        head_blocked, left_blocked, sensors_valid;
  logic [15:0] move_count;

  always #5 clk = ~clk;

  robot_position_tracker #(
    .ROWS(10), .COLS(20), .START_ROW(1), .START_COL(1), .START_ORIENT(2'b00)
  ) dut (
    .clock_50(clk),
    .reset_key(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_code(cmd_code),
    .cmd_ready(cmd_ready),
    .cmd_done(cmd_done),
    .collision(collision),
    .map_rd_en(map_rd_en),
    .map_rd_row(map_rd_row),
    .map_rd_col(map_rd_col),
    .map_wall(map_wall),
    .robot_row(robot_row),
    .robot_column(robot_column),
    .robot_orientation(robot_orientation),
    .head_blocked(head_blocked),
    .left_blocked(left_blocked),
    .sensors_valid(sensors_valid),
    .move_count(move_count)
  );

  // Map ROM model: one-cycle read latency
  bit wall [0:11][0:21];
  always @(posedge clk) begin
    if (map_rd_en && map_rd_row <= 6'd11 && map_rd_col <= 6'd21)
      map_wall <= wall[int'(map_rd_row)][int'(map_rd_col)];
    else
      map_wall <= 1'b0;
  end

  // Read and position monitor
  int nreads = 0, bad_reads = 0, bad_pos = 0;
  int last_r = 0, last_c = 0;
  always @(negedge clk) begin
    if (map_rd_en) begin
      nreads = nreads + 1;
      last_r = int'(map_rd_row);
      last_c = int'(map_rd_col);
      if (map_rd_row < 6'd1 || map_rd_row > 6'd10 || map_rd_col < 6'd1 || map_rd_col > 6'd20)
        bad_reads = bad_reads + 1;
    end
    if (rst_n && (robot_row < 6'd1 || robot_row > 6'd10 ||
                  robot_column < 6'd1 || robot_column > 6'd20))
      bad_pos = bad_pos + 1;
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"},  int'(cmd_ready), 0);
    chk({tag, "_done"},   int'(cmd_done), 0);
    chk({tag, "_coll"},   int'(collision), 0);
    chk({tag, "_rd_en"},  int'(map_rd_en), 0);
    chk({tag, "_rd_row"}, int'(map_rd_row), 0);
    chk({tag, "_rd_col"}, int'(map_rd_col), 0);
    chk({tag, "_row"},    int'(robot_row), 1);
    chk({tag, "_col"},    int'(robot_column), 1);
    chk({tag, "_ori"},    int'(robot_orientation), 0);
    chk({tag, "_head"},   int'(head_blocked), 1);
    chk({tag, "_left"},   int'(left_blocked), 1);
    chk({tag, "_mc"},     int'(move_count), 0);
    chk({tag, "_sv"},     int'(sensors_valid), 0);
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) chk("ready_timeout", 0, 1);
  endtask

  // Issue one command and check pulses and the five-cycle turnaround
  task automatic do_cmd(input logic [1:0] code, input int exp_coll);
    int lat;
    wait_ready();
    cmd_valid = 1'b1;
    cmd_code  = code;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("done_pulse",  int'(cmd_done), 1);
    chk("coll_pulse",  int'(collision), exp_coll);
    chk("ready_low",   int'(cmd_ready), 0);
    @(negedge clk);
    chk("done_clear",  int'(cmd_done), 0);
    chk("coll_clear",  int'(collision), 0);
    lat = 2;
    while (!cmd_ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("turnaround", lat, 5);
  endtask

  typedef struct {
    logic [1:0] code;
    int row, col, ori, head, left, mc, coll, nrd, lr, lc;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int r0, lat, dones, last, gapbad, cyc;

    // code, row, col, ori, head, left, mc, coll, reads, last read row/col
    tbl[0]  = '{2'd2, 1, 1, 2, 0, 1, 0, 0, 1, 1, 2};
    tbl[1]  = '{2'd0, 1, 2, 2, 1, 1, 1, 0, 1, 1, 3};
    tbl[2]  = '{2'd0, 1, 2, 2, 1, 1, 1, 1, 1, 1, 3};
    tbl[3]  = '{2'd2, 1, 2, 1, 0, 1, 1, 0, 2, 1, 3};
    tbl[4]  = '{2'd0, 2, 2, 1, 0, 0, 2, 0, 2, 2, 3};
    tbl[5]  = '{2'd1, 2, 2, 2, 0, 0, 2, 0, 2, 1, 2};
    tbl[6]  = '{2'd1, 2, 2, 0, 0, 0, 2, 0, 2, 2, 1};
    tbl[7]  = '{2'd3, 2, 2, 0, 0, 0, 2, 0, 2, 2, 1};
    tbl[8]  = '{2'd1, 2, 2, 3, 0, 0, 2, 0, 2, 3, 2};
    tbl[9]  = '{2'd0, 2, 1, 3, 1, 0, 3, 0, 1, 3, 1};
    tbl[10] = '{2'd0, 2, 1, 3, 1, 0, 3, 1, 1, 3, 1};
    tbl[11] = '{2'd1, 2, 1, 1, 0, 0, 3, 0, 2, 2, 2};

    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 22; c++)
        wall[r][c] = 1'b0;
    wall[1][3] = 1'b1;

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_code  = 2'b11;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");

    // Reset release: corner start, both neighbours off-map, no reads
    r0 = nreads;
    rst_n = 1'b1;
    lat = 0;
    while (!sensors_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("sv_rise", lat, 4);
    chk("init_reads", nreads - r0, 0);
    chk("init_head", int'(head_blocked), 1);
    chk("init_left", int'(left_blocked), 1);
    chk("init_row", int'(robot_row), 1);
    chk("init_col", int'(robot_column), 1);
    chk("init_ori", int'(robot_orientation), 0);

    // Directed command table
    for (int i = 0; i < 12; i++) begin
      r0 = nreads;
      do_cmd(tbl[i].code, tbl[i].coll);
      chk("t_row",   int'(robot_row), tbl[i].row);
      chk("t_col",   int'(robot_column), tbl[i].col);
      chk("t_ori",   int'(robot_orientation), tbl[i].ori);
      chk("t_head",  int'(head_blocked), tbl[i].head);
      chk("t_left",  int'(left_blocked), tbl[i].left);
      chk("t_mc",    int'(move_count), tbl[i].mc);
      chk("t_nreads", nreads - r0, tbl[i].nrd);
      chk("t_last_r", last_r, tbl[i].lr);
      chk("t_last_c", last_c, tbl[i].lc);
    end

    // Walk south to the bottom edge, then bump into it
    for (int k = 0; k < 8; k++) do_cmd(2'd0, 0);
    chk("south_row",  int'(robot_row), 10);
    chk("south_head", int'(head_blocked), 1);
    chk("south_left", int'(left_blocked), 0);
    chk("south_mc",   int'(move_count), 11);
    do_cmd(2'd0, 1);
    chk("edge_row", int'(robot_row), 10);
    chk("edge_mc",  int'(move_count), 11);
    chk("no_oob_reads", bad_reads, 0);

    // Reset asserted during W_LEFT after a forward move
    do_cmd(2'd1, 0);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_code  = 2'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid_col", int'(robot_column), 2);
    chk("mid_mc",  int'(move_count), 12);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("abort");
    @(negedge clk);
    r0 = nreads;
    rst_n = 1'b1;
    lat = 0;
    while (!sensors_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("resense_lat",   lat, 4);
    chk("resense_reads", nreads - r0, 0);
    chk("resense_row",   int'(robot_row), 1);
    chk("resense_mc",    int'(move_count), 0);

    // cmd_valid held high: one acceptance every five cycles
    wall[1][3] = 1'b0;
    do_cmd(2'd2, 0);
    cmd_valid = 1'b1;
    cmd_code  = 2'd0;
    dones = 0; last = 0; gapbad = 0; cyc = 0;
    while (dones < 100 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (cmd_done) begin
        if (dones > 0 && cyc - last != 5) gapbad++;
        last = cyc;
        dones++;
      end
    end
    cmd_valid = 1'b0;
    chk("held_dones", dones, 100);
    chk("held_gaps",  gapbad, 0);
    wait_ready();
    chk("held_row", int'(robot_row), 1);
    chk("held_col", int'(robot_column), 20);
    chk("held_mc",  int'(move_count), 19);
    chk("bounds",   bad_pos, 0);
    chk("oob_reads_final", bad_reads, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
